// File: rtl/pipe_reg_chain.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake,
// bubble collapsing, synchronous flush and occupancy count.
module pipe_reg_chain #(
  parameter int unsigned    DW      = 32,
  parameter int unsigned    DEPTH   = 1,
  parameter logic [DW-1:0]  RST_VAL = {DW{1'b0}},
  parameter int unsigned    CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0] v_q;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] mv;
  logic [CW-1:0]    count_q;
  logic             in_xfer;
  logic             out_xfer;

  // Ready chain from the output side back to stage 0; an empty stage always accepts.
  always_comb begin : ready_chain
    logic down_acc;
    acc      = '0;
    mv       = '0;
    down_acc = out_ready_i;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      mv[i]    = v_q[i] & down_acc;
      acc[i]   = ~v_q[i] | mv[i];
      down_acc = acc[i];
    end
  end

  assign in_ready_o  = acc[0] & ~flush_i;
  assign out_valid_o = v_q[DEPTH-1] & ~flush_i;
  assign out_data_o  = d_q[DEPTH-1];
  assign count_o     = count_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  // Stage state; data registers only load when a valid entry arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= RST_VAL;
      end
    end else if (flush_i) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      if (acc[0]) begin
        v_q[0] <= in_valid_i;
        if (in_valid_i) begin
          d_q[0] <= in_data_i;
        end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (acc[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            d_q[i] <= d_q[i-1];
          end
        end
      end
      unique case ({in_xfer, out_xfer})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef DISABLE_SV_ASSERTION
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({in_valid_i, out_ready_i, flush_i}));

  a_count_matches_valid: assert property (@(posedge clk) disable iff (!rst_n)
    count_q == CW'($countones(v_q)));
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: DEPTH=3 and DEPTH=1 instances share stimulus and are
// checked against a queue model where the head is visible once it has aged DEPTH-1 edges.
module tb_pipe_reg_chain;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       ir3, ov3, ir1, ov1;
  logic [7:0] od3, od1;
  logic [1:0] cnt3;
  logic [0:0] cnt1;

  pipe_reg_chain #(.DW(8), .DEPTH(3), .RST_VAL(8'hA5)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir3), .in_data_i(in_data),
    .out_valid_o(ov3), .out_ready_i(out_ready), .out_data_o(od3),
    .count_o(cnt3)
  );

  pipe_reg_chain #(.DW(8), .DEPTH(1), .RST_VAL(8'hA5)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
    .count_o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         ntests = 0;
  int         nfail  = 0;
  int         cyc    = 0;
  bit         known  = 0;
  logic [7:0] q3 [$];
  int         t3 [$];
  logic [7:0] q1 [$];
  int         t1 [$];

  function automatic bit model_ov(int depth, int n, int head_t);
    return !flush && n > 0 && (cyc - head_t) >= depth - 1;
  endfunction

  function automatic bit model_ir(int depth, int n, bit ov);
    return !flush && (n < depth || (ov && out_ready));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit iv, input logic [7:0] dat, input bit rdy);
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = dat;
    out_ready = rdy;
  endtask

  task automatic check_models();
    bit eov3, eir3, eov1, eir1;
    if (!known) return;
    eov3 = model_ov(3, q3.size(), (q3.size() > 0) ? t3[0] : 0);
    eir3 = model_ir(3, q3.size(), eov3);
    eov1 = model_ov(1, q1.size(), (q1.size() > 0) ? t1[0] : 0);
    eir1 = model_ir(1, q1.size(), eov1);
    chk("d3_in_ready",  32'(ir3),  32'(eir3));
    chk("d3_out_valid", 32'(ov3),  32'(eov3));
    chk("d3_count",     32'(cnt3), 32'(q3.size()));
    if (eov3) chk("d3_out_data", 32'(od3), 32'(q3[0]));
    chk("d1_in_ready",  32'(ir1),  32'(eir1));
    chk("d1_out_valid", 32'(ov1),  32'(eov1));
    chk("d1_count",     32'(cnt1), 32'(q1.size()));
    if (eov1) chk("d1_out_data", 32'(od1), 32'(q1[0]));
  endtask

  // Advance one edge and apply the transfers the model predicts for the current inputs.
  task automatic tick();
    bit eov3, eov1, in3, out3, in1, out1;
    eov3 = model_ov(3, q3.size(), (q3.size() > 0) ? t3[0] : 0);
    eov1 = model_ov(1, q1.size(), (q1.size() > 0) ? t1[0] : 0);
    out3 = eov3 && out_ready;
    out1 = eov1 && out_ready;
    in3  = in_valid && model_ir(3, q3.size(), eov3);
    in1  = in_valid && model_ir(1, q1.size(), eov1);
    @(posedge clk);
    if (!rst_n || flush) begin
      q3.delete(); t3.delete(); q1.delete(); t1.delete();
      if (!rst_n) known = 1;
    end else begin
      if (out3) begin void'(q3.pop_front()); void'(t3.pop_front()); end
      if (out1) begin void'(q1.pop_front()); void'(t1.pop_front()); end
      if (in3) begin q3.push_back(in_data); t3.push_back(cyc + 1); end
      if (in1) begin q1.push_back(in_data); t1.push_back(cyc + 1); end
    end
    cyc++;
    #1;
  endtask

  task automatic step(input bit r, input bit f, input bit iv, input logic [7:0] dat, input bit rdy);
    drive(r, f, iv, dat, rdy);
    @(negedge clk);
    check_models();
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 8'h00, 0);
    @(posedge clk);
    #1;

    // Reset held for two cycles
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 1);
    @(negedge clk);
    check_models();
    chk("rst_d3_out_valid", 32'(ov3),  32'd0);
    chk("rst_d3_out_data",  32'(od3),  32'hA5);
    chk("rst_d3_count",     32'(cnt3), 32'd0);
    chk("rst_d3_in_ready",  32'(ir3),  32'd1);
    chk("rst_d1_out_data",  32'(od1),  32'hA5);
    tick();

    // Streaming 0x01..0x08 with no backpressure
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 1, 8'(k), 1);
      @(negedge clk);
      check_models();
      if (k >= 4) begin
        chk("stream_count",     32'(cnt3), 32'd3);
        chk("stream_out_valid", 32'(ov3),  32'd1);
        chk("stream_out_data",  32'(od3),  32'(k - 3));
      end
      tick();
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 8'h00, 1);

    // Backpressure and bubble collapse
    step(1, 0, 1, 8'h10, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h11, 0);
    step(1, 0, 1, 8'h12, 0);
    drive(1, 0, 1, 8'h13, 0);
    @(negedge clk);
    check_models();
    chk("bp_count",     32'(cnt3), 32'd3);
    chk("bp_in_ready",  32'(ir3),  32'd0);
    chk("bp_out_data",  32'(od3),  32'h10);
    tick();
    drive(1, 0, 0, 8'h00, 0);
    @(negedge clk);
    check_models();
    chk("bp_stable_data",  32'(od3), 32'h10);
    chk("bp_stable_valid", 32'(ov3), 32'd1);
    tick();

    // Full with simultaneous push and pop
    drive(1, 0, 1, 8'h20, 1);
    @(negedge clk);
    check_models();
    chk("pp_in_ready", 32'(ir3), 32'd1);
    chk("pp_out_data", 32'(od3), 32'h10);
    tick();
    drive(1, 0, 0, 8'h00, 1);
    @(negedge clk);
    check_models();
    chk("pp_count",    32'(cnt3), 32'd3);
    chk("pp_next_out", 32'(od3),  32'h11);
    tick();
    for (int k = 0; k < 5; k++) step(1, 0, 0, 8'h00, 1);

    // Flush with input offered in the same cycle
    step(1, 0, 1, 8'h30, 0);
    step(1, 0, 1, 8'h31, 0);
    step(1, 0, 0, 8'h00, 0);
    drive(1, 1, 1, 8'h32, 1);
    @(negedge clk);
    check_models();
    chk("flush_in_ready",  32'(ir3), 32'd0);
    chk("flush_out_valid", 32'(ov3), 32'd0);
    tick();
    drive(1, 0, 0, 8'h00, 1);
    @(negedge clk);
    check_models();
    chk("post_flush_count", 32'(cnt3), 32'd0);
    chk("post_flush_valid", 32'(ov3),  32'd0);
    tick();
    for (int k = 0; k < 3; k++) step(1, 0, 0, 8'h00, 1);

    // Reset together with flush while holding entries
    step(1, 0, 1, 8'h40, 0);
    step(1, 0, 1, 8'h41, 0);
    step(1, 0, 1, 8'h42, 0);
    step(0, 1, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    @(negedge clk);
    check_models();
    chk("rstm_d3_count",    32'(cnt3), 32'd0);
    chk("rstm_d3_out_data", 32'(od3),  32'hA5);
    chk("rstm_d3_valid",    32'(ov3),  32'd0);
    chk("rstm_d1_out_data", 32'(od1),  32'hA5);
    chk("rstm_d1_count",    32'(cnt1), 32'd0);
    tick();

    // Single-stage full and push/pop
    step(1, 0, 1, 8'h50, 0);
    drive(1, 0, 1, 8'h51, 0);
    @(negedge clk);
    check_models();
    chk("d1_full_count",    32'(cnt1), 32'd1);
    chk("d1_full_valid",    32'(ov1),  32'd1);
    chk("d1_full_in_ready", 32'(ir1),  32'd0);
    chk("d1_full_data",     32'(od1),  32'h50);
    tick();
    drive(1, 0, 1, 8'h52, 1);
    @(negedge clk);
    check_models();
    chk("d1_pp_in_ready", 32'(ir1), 32'd1);
    chk("d1_pp_out_data", 32'(od1), 32'h50);
    tick();
    drive(1, 0, 0, 8'h00, 0);
    @(negedge clk);
    check_models();
    chk("d1_pp_count", 32'(cnt1), 32'd1);
    chk("d1_pp_next",  32'(od1),  32'h52);
    tick();
    step(1, 1, 0, 8'h00, 1);

    // Randomised traffic against the queue model
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           8'($urandom()),
           ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
